dkey_tx: RTL and testbench
==========================

# dkey_tx

Serial key transmitter for the digital lock. The block latches a parallel key code on a start request and shifts it out MSB-first on a single-bit line, one bit per clock. Bits change on the rising edge so they are stable when the lock samples on the falling edge. After the last bit it samples the lock's `unlock` response and reports the result. It sits between the user or test controller and the lock's `b_in` / `unlock` pins.

## Interface
Parameters:
- `CODE_LEN`, default 6: key length in bits; must be ≥ 1.
- `PRE_LEN`, default 2: number of preamble zero bits. Used only when the preamble feature is compiled in; must be ≥ 1.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `clear`  in  1  reset; synchronous, active-high.
- `start`  in  1  request to transmit; sampled only in IDLE.
- `code`  in  CODE_LEN  key to send; latched when `start` is accepted.
- `unlock`  in  1  response from the lock.
- `b_out`  out  1  serial key bit; connects to the lock's `b_in`.
- `b_valid`  out  1  high while `b_out` carries a preamble or key bit.
- `busy`  out  1  high from the cycle after acceptance until the last bit has been sent.
- `done`  out  1  one-cycle pulse marking the end of a transmission.
- `granted`  out  1  sampled `unlock` result; held until the next accepted `start`.

## Operation
- States: IDLE, PRE (preamble builds only), SEND.
- Reset: when `clear` is high at a rising edge, the block enters IDLE on that edge.
  - Outputs after reset: `b_out`=0, `b_valid`=0, `busy`=0, `done`=0, `granted`=0.
  - Shift register and bit counter clear to 0.
  - Reset has priority over every other input.
- IDLE:
  - `b_out`=0 (idle level), `b_valid`=0, `busy`=0.
  - When `start`=1, latch `code`, clear `granted`, load the counter, and go to PRE or SEND.
- PRE: drive `b_out`=0 for PRE_LEN cycles, then go to SEND. This flushes any partial sequence in the lock back to its initial state.
- SEND:
  - Drive `code[CODE_LEN-1-i]` during the i-th SEND cycle.
  - At the edge that ends the last SEND cycle:
    - `granted` <= `unlock`
    - `done` <= 1 for one cycle
    - `b_out` <= 0, `b_valid` <= 0, `busy` <= 0
    - state <= IDLE
- `start` while not in IDLE is ignored. Changes to `code` while busy have no effect.
- `start` high during the `done` cycle is accepted, because the block is already in IDLE.
- Counter width is $clog2(CODE_LEN+PRE_LEN+1). It counts down, and no wrap-around occurs.
- `clear` asserted mid-transmission aborts it: no `done` pulse, and `granted` is forced to 0.

## Timing
- Let `start` be accepted at rising edge t (no preamble):
  - Bit i is on `b_out` during cycle t+1+i, for i = 0..CODE_LEN-1.
  - `busy` and `b_valid` are high during cycles t+1 .. t+CODE_LEN.
  - `done` is high during cycle t+CODE_LEN+1, and `granted` is valid from that cycle on.
- `unlock` is sampled at the edge closing cycle t+CODE_LEN. The lock updates `unlock` at the falling edge inside that cycle, which gives half a cycle of setup.
- With the preamble, every figure above shifts later by PRE_LEN cycles.
- Back-to-back transmissions: a second accepted `start` occurs at the earliest at edge t+CODE_LEN+1(+PRE_LEN). Its first bit appears one cycle later.

## Configuration
- `DKEY_PREAMBLE_EN` defined:
  - The PRE state exists.
  - Each transmission sends PRE_LEN zeros with `b_valid`=1 before the key.
- `DKEY_PREAMBLE_EN` undefined:
  - The PRE state and its logic are absent.
  - The transition is IDLE -> SEND directly, and PRE_LEN is unused.

## Structure
- Shared package `dkey_pkg` holds:
  - the state enum (IDLE, PRE, SEND)
  - `DKEY_DEFAULT_LEN` = 6
  - `DKEY_DEFAULT_CODE` = 6'b101100
- Sub-module `dkey_piso`: a CODE_LEN-bit parallel-load, MSB-first shift register.
  - Inputs: load, shift, data.
  - Output: current MSB.
  - Reset synchronously by `clear`.
- `dkey_tx` contains the FSM, the counter and the result capture.

## Test plan
- `code`=101100, `unlock` driven by a lock model, `start` at t -> `b_out` is 1,0,1,1,0,0 in cycles t+1..t+6; `done`=1 at t+7; `granted`=1.
- `code`=101101 -> same cadence; `done` at t+7; `granted`=0.
- `start` pulsed again at t+3 with `code`=000000 -> ignored; the bit stream is unchanged; exactly one `done` pulse.
- `clear` high at edge t+3 -> from t+3: `b_out`, `b_valid`, `busy`, `done`, `granted` all 0 with no `done` pulse; a later `start` transmits correctly.
- `start` held high through the `done` cycle -> second burst begins with its first bit at t+8; `granted` clears at acceptance.
- `DKEY_PREAMBLE_EN` defined, PRE_LEN=2, `code`=101100 -> `b_out` is 0,0,1,0,1,1,0,0 in cycles t+1..t+8; `done` at t+9; `granted`=1.

Source files
------------

// File: rtl/dkey_pkg.sv
// dkey_pkg: shared state encoding and default key for the serial key transmitter.
package dkey_pkg;
  typedef enum logic [1:0] {IDLE, PRE, SEND} dkey_state_t;
  localparam int DKEY_DEFAULT_LEN = 6;
  localparam logic [DKEY_DEFAULT_LEN-1:0] DKEY_DEFAULT_CODE = 6'b101100;
endpackage

// File: rtl/dkey_piso.sv
// dkey_piso: parallel-load, MSB-first shift register.
module dkey_piso
  import dkey_pkg::*;
#(
  parameter int W = DKEY_DEFAULT_LEN
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] data,
  output logic         msb
);
  logic [W-1:0] r_sr;
  always_ff @(posedge clk)
    r_sr <= clear ? '0 : load ? data : shift ? r_sr << 1 : r_sr;
  assign msb = r_sr[W-1];
endmodule

// File: rtl/dkey_tx.sv
// dkey_tx: latches a key on start, shifts it out MSB-first, then captures unlock.
// Optional preamble of PRE_LEN zero bits when DKEY_PREAMBLE_EN is defined.
module dkey_tx
  import dkey_pkg::*;
#(
  parameter int CODE_LEN = DKEY_DEFAULT_LEN,
  parameter int PRE_LEN  = 2
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                start,
  input  logic [CODE_LEN-1:0] code,
  input  logic                unlock,
  output logic                b_out,
  output logic                b_valid,
  output logic                busy,
  output logic                done,
  output logic                granted
);
  localparam int CW = $clog2(CODE_LEN + PRE_LEN + 1);
  dkey_state_t         r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_b_out, r_b_valid, r_busy, r_done, r_granted;
  logic                w_msb, w_load, w_shift;
  logic [CODE_LEN-1:0] w_load_data;
  assign w_load = (r_state == IDLE) && start;
`ifdef DKEY_PREAMBLE_EN
  // The register holds the whole key; its MSB is taken when PRE hands over to SEND.
  assign w_load_data = code;
  assign w_shift = (r_state == SEND && r_cnt != '0) || (r_state == PRE && r_cnt == '0);
`else
  // The first bit goes straight to b_out at acceptance, so the register starts one bit ahead.
  assign w_load_data = code << 1;
  assign w_shift = (r_state == SEND) && (r_cnt != '0);
`endif
  dkey_piso #(.W(CODE_LEN)) u_piso (
    .clk  (clk),
    .clear(clear),
    .load (w_load),
    .shift(w_shift),
    .data (w_load_data),
    .msb  (w_msb)
  );
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_b_out   <= 1'b0;
      r_b_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_granted <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_granted <= 1'b0;
          r_busy    <= 1'b1;
          r_b_valid <= 1'b1;
`ifdef DKEY_PREAMBLE_EN
          r_state   <= PRE;
          r_cnt     <= CW'(PRE_LEN - 1);
          r_b_out   <= 1'b0;
`else
          r_state   <= SEND;
          r_cnt     <= CW'(CODE_LEN - 1);
          r_b_out   <= code[CODE_LEN-1];
`endif
        end
`ifdef DKEY_PREAMBLE_EN
        PRE: if (r_cnt == '0) begin
          r_state <= SEND;
          r_cnt   <= CW'(CODE_LEN - 1);
          r_b_out <= w_msb;
        end else
          r_cnt <= r_cnt - 1'b1;
`endif
        SEND: if (r_cnt == '0) begin
          r_state   <= IDLE;
          r_granted <= unlock;
          r_done    <= 1'b1;
          r_b_out   <= 1'b0;
          r_b_valid <= 1'b0;
          r_busy    <= 1'b0;
        end else begin
          r_cnt   <= r_cnt - 1'b1;
          r_b_out <= w_msb;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign b_out   = r_b_out;
  assign b_valid = r_b_valid;
  assign busy    = r_busy;
  assign done    = r_done;
  assign granted = r_granted;
endmodule

// File: tb/tb_dkey_tx.sv
// tb_dkey_tx: randomized scoreboard bench for dkey_tx with a sequence-detecting lock model.
module tb_dkey_tx;
  localparam int CL = 6;
`ifdef DKEY_PREAMBLE_EN
  localparam int PL = 2;
`else
  localparam int PL = 0;
`endif
  localparam int L = CL + PL;
  localparam logic [CL-1:0] KEY = 6'b101100;

  logic clk = 0, clear = 1, start = 0, unlock = 0;
  logic [CL-1:0] code = '0;
  logic b_out, b_valid, busy, done, granted;
  int checks = 0, failures = 0, cyc = 0;
  bit run = 0;

  dkey_tx #(.CODE_LEN(CL), .PRE_LEN(2)) dut (
    .clk(clk), .clear(clear), .start(start), .code(code), .unlock(unlock),
    .b_out(b_out), .b_valid(b_valid), .busy(busy), .done(done), .granted(granted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  // Lock: samples b_in on the falling edge and opens when the last CL bits equal KEY.
  logic [CL-1:0] hist = '0;
  always @(negedge clk) begin
    if (clear) hist = '0;
    else if (b_valid) hist = {hist[CL-2:0], b_out};
    unlock = (hist == KEY);
  end

  typedef struct { logic [31:0] frame; int len; logic g; int done_cyc; } exp_t;
  exp_t q[$];

  logic [31:0] col = 0;
  int n = 0;
  logic g_hold = 0, prev_done = 0, post_clr = 0;
  always @(negedge clk) if (run) begin
    exp_t e;
    if (post_clr) begin
      chk("clr_bout", b_out, 0); chk("clr_valid", b_valid, 0);
      chk("clr_busy", busy, 0); chk("clr_done", done, 0); chk("clr_granted", granted, 0);
      post_clr = 0;
    end
    chk("busy_eq_valid", busy, b_valid);
    if (!b_valid) chk("idle_bout", b_out, 0);
    else begin col = {col[30:0], b_out}; n++; end
    if (prev_done) chk("done_width", done, 0);
    if (done) begin
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("frame", col, e.frame);
        chk("frame_len", n, e.len);
        chk("done_cycle", cyc, e.done_cyc);
        chk("granted_done", granted, e.g);
        g_hold = e.g;
      end
      col = 0; n = 0;
    end else if (busy) begin
      chk("granted_busy", granted, 0);
      g_hold = 0;
    end else chk("granted_hold", granted, g_hold);
    prev_done = done;
    if (clear) begin col = 0; n = 0; g_hold = 0; post_clr = 1; end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic xmit(input logic [CL-1:0] c, input bit noise);
    exp_t e;
    start = 1; code = c;
    tick();
    e.frame = 32'(c); e.len = L; e.g = (c == KEY); e.done_cyc = cyc + L;
    q.push_back(e);
    for (int k = 0; k < L; k++) begin
      start = noise ? 1'($urandom) : 1'b0;
      code = CL'($urandom);
      tick();
    end
    start = 0;
  endtask

  initial begin
    tick(); tick();
    @(negedge clk);
    chk("rst_bout", b_out, 0); chk("rst_valid", b_valid, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_granted", granted, 0);
    @(posedge clk); #1;
    clear = 0; run = 1;
    tick();
    xmit(KEY, 0);
    tick(); tick();
    xmit(6'b101101, 0);
    tick();
    start = 1; code = KEY; tick();
    start = 1; code = '0; tick();
    start = 0; tick();
    clear = 1; tick();
    clear = 0; tick();
    xmit(KEY, 1);
    xmit(KEY, 0);
    tick();
    clear = 1; tick();
    clear = 0; tick();
    xmit(6'b000000, 1);
    repeat (40) begin
      int gap = $urandom_range(0, 2);
      repeat (gap) begin start = 0; code = CL'($urandom); tick(); end
      xmit(($urandom_range(0, 2) == 0) ? KEY : CL'($urandom), 1);
    end
    for (int w = 0; w < 50 && q.size() != 0; w++) tick();
    chk("queue_drained", q.size(), 0);
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
